// File: rtl/sr_latch_controller.sv
// sr_latch_controller
//   Arbitrates two level-held requests (set / clear) and drives an external
//   SR latch with a timed S or R pulse, then a guard gap with S=R=0. After the
//   gap it compares the latch feedback against the commanded value. All
//   outputs are registered.
//
// Parameters
//   PULSE_W  cycles S or R stays high (1..15)
//   GAP_W    guard cycles with S=R=0 after each pulse (1..15)
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   set_req   request to drive the latch to Q=1 (held until set_ack)
//   clr_req   request to drive the latch to Q=0 (held until clr_ack)
//   q_fb      latch Q fed back from the external SR latch
//   S, R      latch drives, never high together
//   set_ack   one-cycle pulse when a set operation completes
//   clr_ack   one-cycle pulse when a clear operation completes
//   busy      high while an operation is in progress
//   q_exp     latch value last commanded
//   mismatch  sticky: q_fb differed from q_exp at a check point
module sr_latch_controller #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic q_exp,
  output logic mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    CHECK
  } state_t;

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  // Direction of the current (or most recent) grant; reset value 0 means
  // "clear was granted last", so set wins the first tie.
  logic       grant_set, grant_set_nx;
  logic       s_nx, r_nx, set_ack_nx, clr_ack_nx, busy_nx, q_exp_nx, mismatch_nx;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    grant_set_nx = grant_set;
    s_nx         = 1'b0;
    r_nx         = 1'b0;
    set_ack_nx   = 1'b0;
    clr_ack_nx   = 1'b0;
    q_exp_nx     = q_exp;
    mismatch_nx  = mismatch;

    case (state)
      IDLE: begin
        if (set_req || clr_req) begin
          // Round-robin on a tie: the side not granted last wins.
          grant_set_nx = set_req && (!clr_req || !grant_set);
          cnt_nx       = '0;
          state_nx     = PULSE;
        end
      end
      PULSE: begin
        s_nx = grant_set;
        r_nx = !grant_set;
        if (cnt == PULSE_LAST) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = CHECK;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      CHECK: begin
        q_exp_nx   = grant_set;
        set_ack_nx = grant_set;
        clr_ack_nx = !grant_set;
        if (q_fb != grant_set) begin
          mismatch_nx = 1'b1;
        end
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // Outputs are registered from the decode of the current state, so every
  // drive appears one cycle after the state that produces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      grant_set <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      set_ack   <= 1'b0;
      clr_ack   <= 1'b0;
      busy      <= 1'b0;
      q_exp     <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      grant_set <= grant_set_nx;
      S         <= s_nx;
      R         <= r_nx;
      set_ack   <= set_ack_nx;
      clr_ack   <= clr_ack_nx;
      busy      <= busy_nx;
      q_exp     <= q_exp_nx;
      mismatch  <= mismatch_nx;
    end
  end

endmodule

// File: doc/sr_latch_controller.md
SR_LATCH_CONTROLLER -- requirements
Module: sr_latch_controller

Interface
REQ-001 Parameter PULSE_W, default 2: cycles an S or R drive pulse stays high (legal 1..15).
REQ-002 Parameter GAP_W, default 1: guard cycles with S=R=0 after each pulse (legal 1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 set_req  input  1  requester A asks to drive latch to Q=1; level, held until set_ack.
REQ-006 clr_req  input  1  requester B asks to drive latch to Q=0; level, held until clr_ack.
REQ-007 q_fb  input  1  Q output fed back from the external SR latch.
REQ-008 S  output  1  set drive to the latch.
REQ-009 R  output  1  reset drive to the latch.
REQ-010 set_ack  output  1  one-cycle pulse: set operation completed.
REQ-011 clr_ack  output  1  one-cycle pulse: clear operation completed.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 q_exp  output  1  latch value the controller last commanded.
REQ-014 mismatch  output  1  sticky flag: q_fb differed from q_exp at a check point.

Function
REQ-015 FSM states IDLE, PULSE, GAP, CHECK; all outputs registered.
REQ-016 IDLE: grant on a cycle where at least one request is high; next state PULSE; busy rises the cycle after the grant cycle.
REQ-017 Arbitration: single request is granted; set_req and clr_req both high -> round-robin; winner is the requester not granted last; after reset, last-grant = clr, so set wins first tie.
REQ-018 PULSE: S=1 (set grant) or R=1 (clear grant) for exactly PULSE_W cycles; the other drive stays 0; then GAP.
REQ-019 S and R are never high in the same cycle, under any input or reset sequence.
REQ-020 GAP: S=R=0 for exactly GAP_W cycles; then CHECK.
REQ-021 CHECK lasts one cycle: q_exp updated to granted value; q_fb compared to the new q_exp; on difference, mismatch set; matching ack pulses high that cycle; next state IDLE.
REQ-022 Grant-to-ack latency = 1 + PULSE_W + GAP_W + 1 cycles from the grant edge; defaults: 5 cycles.
REQ-023 Requests dropped mid-operation do not abort it; ack still issued; requester must deassert in the ack cycle or it is granted again.
REQ-024 Back-to-back: IDLE lasts at least one cycle between operations; S/R idle for at least GAP_W+2 cycles between pulses.
REQ-025 A request matching current q_exp is still executed in full (no skip).
REQ-026 Pulse and gap counters are 4 bits; counter saturation/wrap never observable on outputs.
REQ-027 mismatch clears only by reset.

Reset
REQ-028 rst high at a clock edge -> next cycle: state IDLE, S=0, R=0, set_ack=0, clr_ack=0, busy=0, q_exp=0, mismatch=0, last-grant=clr, counters 0.
REQ-029 Reset mid-PULSE drops S/R to 0 the cycle after the reset edge; no ack is issued for the aborted operation.
REQ-030 rst dominates all requests in the same cycle; requests are not granted until the first edge with rst low.

Verification
REQ-031 Reset, set_req=1 with q_fb tied to S-latch model -> S high cycles 2-3 after grant, gap cycle 4, set_ack at cycle 5, q_exp=1, mismatch=0.
REQ-032 set_req and clr_req high together from reset -> set granted first, then clr; S pulse precedes R pulse; R never overlaps S; q_exp ends 0.
REQ-033 Continuous requests on both lines for 6 operations -> grants alternate set, clr, set...; each ack pulse one cycle wide.
REQ-034 q_fb forced 0 during set operation -> mismatch=1 at CHECK and stays 1 until rst.
REQ-035 rst asserted during second PULSE cycle -> S=0 next cycle, no set_ack, busy=0, q_exp=0.
REQ-036 PULSE_W=1, GAP_W=3 -> pulse 1 cycle, gap 3 cycles, ack latency 6 cycles.
